// File: rtl/pci_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pci_pkg
// Brief   : PCI bus command codes and target state encoding, shared by the
//           initiator and target sides.
// Revision: 1.0
// ============================================================================
package pci_pkg;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_BUSY    = 3'd1;
    localparam logic [2:0] ST_WR_DATA = 3'd2;
    localparam logic [2:0] ST_RD_TURN = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;
    localparam logic [2:0] ST_TURN    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_BUSY    = ST_BUSY,
        S_WR_DATA = ST_WR_DATA,
        S_RD_TURN = ST_RD_TURN,
        S_RD_DATA = ST_RD_DATA,
        S_TURN    = ST_TURN
    } tgt_state_t;

endpackage
`default_nettype wire

// File: rtl/pci_target_if.sv
`default_nettype none
// ============================================================================
// Module  : pci_target_if
// Brief   : Shared PCI AD/C_BE/FRAME/IRDY/TRDY/DEVSEL/STOP bus bundle.
// Revision: 1.0
// ============================================================================
interface pci_target_if;

    logic [31:0] ad_i;
    logic [31:0] ad_o;
    logic        ad_oe;
    logic [3:0]  c_be_n;
    logic        frame_n;
    logic        irdy_n;
    logic        trdy_n;
    logic        devsel_n;
    logic        stop_n;
    logic        ctl_oe;

    modport slave (
        input  ad_i, c_be_n, frame_n, irdy_n,
        output ad_o, ad_oe, trdy_n, devsel_n, stop_n, ctl_oe
    );

    modport master (
        output ad_i, c_be_n, frame_n, irdy_n,
        input  ad_o, ad_oe, trdy_n, devsel_n, stop_n, ctl_oe
    );

endinterface
`default_nettype wire

// File: rtl/pci_target_mem.sv
`default_nettype none
// ============================================================================
// Module  : pci_target_mem
// Brief   : Dword RAM with per-byte synchronous write and combinational read.
// Revision: 1.0
// ============================================================================
module pci_target_mem #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic [3:0]        wr_be,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/pci_target.sv
`default_nettype none
// ============================================================================
// Module  : pci_target
// Brief   : PCI memory-space target: decodes its window, claims MEM_RD/MEM_WR
//           and completes single or linear burst data phases from local RAM.
// Revision: 1.0
// ============================================================================
module pci_target
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          ADDR_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    pci_target_if.slave bus
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    tgt_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              disc_q, disc_d;
    logic              trdy_n_q, trdy_n_d;
    logic              devsel_n_q, devsel_n_d;
    logic              ctl_oe_q, ctl_oe_d;
    logic              ad_oe_q, ad_oe_d;
    logic [31:0]       ad_o_q, ad_o_d;

    logic              addr_hit;
    logic              in_data;
    logic              xfer;
    logic              at_last;
    logic [3:0]        mem_we;
    logic [31:0]       mem_rdata;

    assign addr_hit = (bus.ad_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign in_data  = (state_q == S_WR_DATA) || (state_q == S_RD_DATA);
    assign xfer     = in_data && !disc_q && !trdy_n_q && !bus.irdy_n;
    assign at_last  = (ptr_q == PTR_LAST);
    assign mem_we   = (xfer && (state_q == S_WR_DATA)) ? ~bus.c_be_n : 4'b0000;

    pci_target_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_be   (mem_we),
        .wr_addr (ptr_q),
        .wr_data (bus.ad_i),
        .rd_addr (ptr_d),
        .rd_data (mem_rdata)
    );

    // The read port looks at the next pointer so registered AD_O is ready
    // in the cycle right after a transfer.
    always_comb begin
        ptr_d = ptr_q;
        if ((state_q == S_IDLE) && !bus.frame_n) begin
            ptr_d = bus.ad_i[ADDR_W+1:2];
        end else if (xfer && !at_last) begin
            ptr_d = ptr_q + ADDR_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        disc_d     = disc_q;
        trdy_n_d   = trdy_n_q;
        devsel_n_d = devsel_n_q;
        ctl_oe_d   = ctl_oe_q;
        ad_oe_d    = ad_oe_q;
        ad_o_d     = ad_o_q;

        case (state_q)
            S_IDLE: begin
                if (!bus.frame_n) begin
                    disc_d = 1'b0;
                    if (addr_hit && (bus.c_be_n == CMD_MEM_WR)) begin
                        state_d    = S_WR_DATA;
                        devsel_n_d = 1'b0;
                        trdy_n_d   = 1'b0;
                        ctl_oe_d   = 1'b1;
                    end else if (addr_hit && (bus.c_be_n == CMD_MEM_RD)) begin
                        state_d    = S_RD_TURN;
                        devsel_n_d = 1'b0;
                        trdy_n_d   = 1'b1;
                        ctl_oe_d   = 1'b1;
                        ad_oe_d    = 1'b0;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                if (bus.frame_n && bus.irdy_n) begin
                    state_d = S_IDLE;
                end
            end

            S_RD_TURN: begin
                state_d  = S_RD_DATA;
                ad_oe_d  = 1'b1;
                trdy_n_d = 1'b0;
                ad_o_d   = mem_rdata;
            end

            S_WR_DATA, S_RD_DATA: begin
                if (disc_q) begin
                    // Disconnected at window end: wait for the initiator to drop FRAME#.
                    if (bus.frame_n) begin
                        state_d    = S_TURN;
                        disc_d     = 1'b0;
                        trdy_n_d   = 1'b1;
                        devsel_n_d = 1'b1;
                        ad_oe_d    = 1'b0;
                    end
                end else if (xfer) begin
                    if (state_q == S_RD_DATA) begin
                        ad_o_d = mem_rdata;
                    end
                    if (bus.frame_n) begin
                        state_d    = S_TURN;
                        trdy_n_d   = 1'b1;
                        devsel_n_d = 1'b1;
                        ad_oe_d    = 1'b0;
                    end else if (at_last) begin
                        disc_d   = 1'b1;
                        trdy_n_d = 1'b1;
                    end
                end
            end

            S_TURN: begin
                state_d  = S_IDLE;
                ctl_oe_d = 1'b0;
            end

            default: begin
                state_d    = S_IDLE;
                disc_d     = 1'b0;
                trdy_n_d   = 1'b1;
                devsel_n_d = 1'b1;
                ctl_oe_d   = 1'b0;
                ad_oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            disc_q     <= 1'b0;
            trdy_n_q   <= 1'b1;
            devsel_n_q <= 1'b1;
            ctl_oe_q   <= 1'b0;
            ad_oe_q    <= 1'b0;
            ad_o_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            disc_q     <= disc_d;
            trdy_n_q   <= trdy_n_d;
            devsel_n_q <= devsel_n_d;
            ctl_oe_q   <= ctl_oe_d;
            ad_oe_q    <= ad_oe_d;
            ad_o_q     <= ad_o_d;
        end
    end

    // STOP# joins TRDY# on the last dword only while the initiator still wants more.
    assign bus.stop_n   = ~(disc_q | (in_data & ~trdy_n_q & at_last & ~bus.frame_n));
    assign bus.trdy_n   = trdy_n_q;
    assign bus.devsel_n = devsel_n_q;
    assign bus.ctl_oe   = ctl_oe_q;
    assign bus.ad_oe    = ad_oe_q;
    assign bus.ad_o     = ad_o_q;

endmodule
`default_nettype wire

// File: tb/tb_pci_target.sv
`default_nettype none
// ============================================================================
// Module  : tb_pci_target
// Brief   : Self-checking bench for pci_target against a dword/byte RAM model.
// Revision: 1.0
// ============================================================================
module tb_pci_target;
    import pci_pkg::*;

    typedef logic [31:0] dw_arr_t [16];
    typedef logic [3:0]  be_arr_t [16];
    typedef bit          wm_arr_t [16];

    localparam logic [31:0] BASE     = 32'h0000_1000;
    localparam logic [4:0]  OBS_TURN = 5'b11101;  // {trdy_n,devsel_n,stop_n,ad_oe,ctl_oe}
    localparam logic [4:0]  OBS_IDLE = 5'b11100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pci_target_if bus();

    pci_target #(
        .BASE_ADDR (BASE),
        .ADDR_W    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] model [16];

    function automatic logic [31:0] merge(input logic [31:0] old_d, input logic [31:0] new_d,
                                          input logic [3:0] be_n);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be_n[b] ? old_d[8*b +: 8] : new_d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [4:0] obs();
        return {bus.trdy_n, bus.devsel_n, bus.stop_n, bus.ad_oe, bus.ctl_oe};
    endfunction

    task automatic idle_bus();
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;
        bus.ad_i    = 32'h0;
        bus.c_be_n  = 4'hF;
    endtask

    // Initiator-side driver: one address phase and n data phases; returns observations only.
    task automatic do_burst(input bit is_wr, input logic [31:0] addr, input int n,
                            input dw_arr_t wd, input be_arr_t be, input wm_arr_t wm,
                            output dw_arr_t rd, output int first_trdy, output int first_devsel,
                            output int viol, output logic [4:0] obs_turn,
                            output logic [4:0] obs_idle, output bit timeout);
        int c = 0;
        int i = 0;
        bit waited = 1'b0;
        bit prev_xfer = 1'b0;
        logic [31:0] prev_ad = 32'h0;
        first_trdy = -1; first_devsel = -1; viol = 0; timeout = 1'b0;
        for (int k = 0; k < 16; k++) rd[k] = 32'h0;
        @(posedge clk); #1;
        bus.frame_n = 1'b0;
        bus.irdy_n  = 1'b1;
        bus.ad_i    = addr;
        bus.c_be_n  = is_wr ? CMD_MEM_WR : CMD_MEM_RD;
        while (i < n && !timeout) begin
            @(posedge clk); #1;
            c++;
            if (wm[i] && !waited) begin
                bus.irdy_n = 1'b1;
                waited = 1'b1;
            end else begin
                bus.irdy_n = 1'b0;
            end
            bus.frame_n = (i == n-1 && bus.irdy_n == 1'b0) ? 1'b1 : 1'b0;
            bus.ad_i    = is_wr ? wd[i] : 32'h0;
            bus.c_be_n  = be[i];
            @(negedge clk);
            if (bus.devsel_n == 1'b0 && first_devsel < 0) first_devsel = c;
            if (first_trdy >= 0) begin
                if (bus.trdy_n !== 1'b0) viol++;
                if (!is_wr && !prev_xfer && bus.ad_o !== prev_ad) viol++;
            end
            if (bus.trdy_n == 1'b0 && first_trdy < 0) first_trdy = c;
            prev_xfer = 1'b0;
            prev_ad = bus.ad_o;
            if (bus.irdy_n == 1'b0 && bus.trdy_n == 1'b0) begin
                rd[i] = bus.ad_o;
                i++;
                waited = 1'b0;
                prev_xfer = 1'b1;
            end
            if (c > 64) timeout = 1'b1;
        end
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        obs_turn = obs();
        @(posedge clk); #1;
        @(negedge clk);
        obs_idle = obs();
    endtask

    task automatic read_dword(input int idx, output logic [31:0] d);
        dw_arr_t wd, rd; be_arr_t be; wm_arr_t wm;
        int ft, fd, v; logic [4:0] ot, oi; bit to;
        for (int k = 0; k < 16; k++) begin wd[k] = 0; be[k] = 0; wm[k] = 0; end
        do_burst(1'b0, BASE + 32'(idx*4), 1, wd, be, wm, rd, ft, fd, v, ot, oi, to);
        d = to ? 32'hXXXX_XXXX : rd[0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_bus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== OBS_IDLE | 5'b00000 || bus.ctl_oe !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: got %b expected %b", obs(), OBS_IDLE);
        end
        checks++;
        if (bus.ad_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_ad_o: got %h expected 00000000", bus.ad_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_preload();
        dw_arr_t wd, rd; be_arr_t be; wm_arr_t wm;
        int ft, fd, v; logic [4:0] ot, oi; bit to;
        for (int k = 0; k < 16; k++) begin wd[k] = $urandom; be[k] = 4'h0; wm[k] = 1'b0; end
        do_burst(1'b1, BASE, 16, wd, be, wm, rd, ft, fd, v, ot, oi, to);
        for (int k = 0; k < 16; k++) model[k] = merge(32'h0, wd[k], be[k]);
        checks++;
        if (to || ft !== 1 || fd !== 1 || v !== 0) begin
            failures++;
            $display("FAIL preload_wr: timeout=%0d trdy_cyc=%0d devsel_cyc=%0d viol=%0d expected 0/1/1/0",
                     to, ft, fd, v);
        end
        checks++;
        if (ot !== OBS_TURN || oi !== OBS_IDLE) begin
            failures++;
            $display("FAIL preload_turn: got %b/%b expected %b/%b", ot, oi, OBS_TURN, OBS_IDLE);
        end
        do_burst(1'b0, BASE, 16, wd, be, wm, rd, ft, fd, v, ot, oi, to);
        checks++;
        if (to || ft !== 2 || v !== 0) begin
            failures++;
            $display("FAIL preload_rd: timeout=%0d trdy_cyc=%0d viol=%0d expected 0/2/0", to, ft, v);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (rd[k] !== model[k]) begin
                failures++;
                $display("FAIL preload_data[%0d]: got %h expected %h", k, rd[k], model[k]);
            end
        end
    endtask

    task automatic test_single_wr_rd();
        dw_arr_t wd, rd; be_arr_t be; wm_arr_t wm;
        int ft, fd, v; logic [4:0] ot, oi; bit to;
        for (int k = 0; k < 16; k++) begin wd[k] = 32'hDEADBEEF; be[k] = 4'h0; wm[k] = 1'b0; end
        do_burst(1'b1, BASE + 32'h4, 1, wd, be, wm, rd, ft, fd, v, ot, oi, to);
        model[1] = merge(model[1], 32'hDEADBEEF, 4'h0);
        checks++;
        if (to || ft !== 1 || fd !== 1) begin
            failures++;
            $display("FAIL single_wr_timing: trdy_cyc=%0d devsel_cyc=%0d expected 1/1", ft, fd);
        end
        do_burst(1'b0, BASE + 32'h4, 1, wd, be, wm, rd, ft, fd, v, ot, oi, to);
        checks++;
        if (to || ft !== 2 || fd !== 1) begin
            failures++;
            $display("FAIL single_rd_timing: trdy_cyc=%0d devsel_cyc=%0d expected 2/1", ft, fd);
        end
        checks++;
        if (rd[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_rd_data: got %h expected deadbeef", rd[0]);
        end
    endtask

    task automatic test_byte_enables();
        dw_arr_t wd, rd; be_arr_t be; wm_arr_t wm;
        int ft, fd, v; logic [4:0] ot, oi; bit to;
        logic [3:0] pat [2];
        logic [31:0] exp_d [2];
        logic [31:0] got;
        pat[0] = 4'b1010; exp_d[0] = 32'hFF34FF78;
        pat[1] = 4'b0101; exp_d[1] = 32'h12FF56FF;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 16; k++) begin wd[k] = 32'hFFFFFFFF; be[k] = 4'h0; wm[k] = 1'b0; end
            do_burst(1'b1, BASE + 32'h8, 1, wd, be, wm, rd, ft, fd, v, ot, oi, to);
            wd[0] = 32'h12345678; be[0] = pat[p];
            do_burst(1'b1, BASE + 32'h8, 1, wd, be, wm, rd, ft, fd, v, ot, oi, to);
            model[2] = merge(32'hFFFFFFFF, 32'h12345678, pat[p]);
            read_dword(2, got);
            checks++;
            if (got !== exp_d[p] || got !== model[2]) begin
                failures++;
                $display("FAIL byte_en_%b: got %h expected %h", pat[p], got, exp_d[p]);
            end
        end
    endtask

    task automatic test_burst_wait();
        dw_arr_t wd, rd; be_arr_t be; wm_arr_t wm;
        int ft, fd, v; logic [4:0] ot, oi; bit to;
        for (int k = 0; k < 16; k++) begin wd[k] = $urandom; be[k] = 4'h0; wm[k] = (k == 1); end
        do_burst(1'b1, BASE + 32'h4, 4, wd, be, wm, rd, ft, fd, v, ot, oi, to);
        for (int k = 0; k < 4; k++) model[1+k] = merge(model[1+k], wd[k], be[k]);
        checks++;
        if (to || v !== 0 || ot !== OBS_TURN) begin
            failures++;
            $display("FAIL burst_wr_hold: timeout=%0d viol=%0d turn=%b expected 0/0/%b", to, v, ot, OBS_TURN);
        end
        do_burst(1'b0, BASE + 32'h4, 4, wd, be, wm, rd, ft, fd, v, ot, oi, to);
        checks++;
        if (to || v !== 0) begin
            failures++;
            $display("FAIL burst_rd_hold: timeout=%0d viol=%0d expected 0/0", to, v);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd[k] !== model[1+k]) begin
                failures++;
                $display("FAIL burst_rd_data[%0d]: got %h expected %h", k, rd[k], model[1+k]);
            end
        end
    endtask

    task automatic test_miss();
        logic [31:0] addrs [2];
        logic [3:0]  cmds  [2];
        logic [31:0] got;
        int bad;
        addrs[0] = 32'h0000_2000; cmds[0] = CMD_MEM_WR;
        addrs[1] = 32'h0000_1000; cmds[1] = 4'b0010;
        for (int m = 0; m < 2; m++) begin
            bad = 0;
            @(posedge clk); #1;
            bus.frame_n = 1'b0; bus.irdy_n = 1'b1; bus.ad_i = addrs[m]; bus.c_be_n = cmds[m];
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                bus.frame_n = 1'b1; bus.irdy_n = (c == 3); bus.ad_i = 32'hA5A5_5A5A; bus.c_be_n = 4'h0;
                @(negedge clk);
                if (bus.devsel_n !== 1'b1 || bus.trdy_n !== 1'b1 || bus.ctl_oe !== 1'b0) bad++;
            end
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("FAIL miss_%0d_claim: claimed cycles=%0d expected 0", m, bad);
            end
            read_dword(0, got);
            checks++;
            if (got !== model[0]) begin
                failures++;
                $display("FAIL miss_%0d_ram: got %h expected %h", m, got, model[0]);
            end
        end
    endtask

    task automatic test_window_end();
        int trdy_lows = 0;
        @(posedge clk); #1;
        bus.frame_n = 1'b0; bus.irdy_n = 1'b1; bus.ad_i = BASE + 32'h3C; bus.c_be_n = CMD_MEM_RD;
        @(posedge clk); #1;
        bus.irdy_n = 1'b0; bus.c_be_n = 4'h0; bus.ad_i = 32'h0;
        @(negedge clk);
        if (!bus.trdy_n) trdy_lows++;
        checks++;
        if ({bus.devsel_n, bus.trdy_n, bus.ad_oe, bus.ctl_oe} !== 4'b0101) begin
            failures++;
            $display("FAIL win_turnaround: got %b expected 0101", {bus.devsel_n, bus.trdy_n, bus.ad_oe, bus.ctl_oe});
        end
        @(posedge clk); #1;
        @(negedge clk);
        if (!bus.trdy_n) trdy_lows++;
        checks++;
        if ({bus.trdy_n, bus.stop_n, bus.ad_oe} !== 3'b001 || bus.ad_o !== model[15]) begin
            failures++;
            $display("FAIL win_stop_data: got %b ad=%h expected 001 ad=%h",
                     {bus.trdy_n, bus.stop_n, bus.ad_oe}, bus.ad_o, model[15]);
        end
        @(posedge clk); #1;
        bus.irdy_n = 1'b1;
        @(negedge clk);
        if (!bus.trdy_n) trdy_lows++;
        checks++;
        if ({bus.trdy_n, bus.stop_n, bus.devsel_n} !== 3'b100) begin
            failures++;
            $display("FAIL win_hold_frame_low: got %b expected 100", {bus.trdy_n, bus.stop_n, bus.devsel_n});
        end
        @(posedge clk); #1;
        bus.frame_n = 1'b1; bus.irdy_n = 1'b0;
        @(negedge clk);
        if (!bus.trdy_n) trdy_lows++;
        checks++;
        if ({bus.trdy_n, bus.stop_n, bus.devsel_n} !== 3'b100) begin
            failures++;
            $display("FAIL win_hold_frame_high: got %b expected 100", {bus.trdy_n, bus.stop_n, bus.devsel_n});
        end
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        if (!bus.trdy_n) trdy_lows++;
        checks++;
        if (obs() !== OBS_TURN) begin
            failures++;
            $display("FAIL win_turn: got %b expected %b", obs(), OBS_TURN);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs() !== OBS_IDLE || trdy_lows !== 1) begin
            failures++;
            $display("FAIL win_idle: got %b transfers=%0d expected %b transfers=1", obs(), trdy_lows, OBS_IDLE);
        end
    endtask

    task automatic test_turn_ignore();
        logic [31:0] d1, got;
        d1 = $urandom;
        @(posedge clk); #1;
        bus.frame_n = 1'b0; bus.irdy_n = 1'b1; bus.ad_i = BASE + 32'h10; bus.c_be_n = CMD_MEM_WR;
        @(posedge clk); #1;
        bus.frame_n = 1'b1; bus.irdy_n = 1'b0; bus.ad_i = d1; bus.c_be_n = 4'h0;
        @(posedge clk); #1;
        model[4] = d1;
        bus.frame_n = 1'b0; bus.irdy_n = 1'b1; bus.ad_i = BASE + 32'h10; bus.c_be_n = CMD_MEM_WR;
        @(negedge clk);
        checks++;
        if (obs() !== OBS_TURN) begin
            failures++;
            $display("FAIL b2b_turn: got %b expected %b", obs(), OBS_TURN);
        end
        @(posedge clk); #1;
        bus.frame_n = 1'b1; bus.irdy_n = 1'b0; bus.ad_i = ~d1; bus.c_be_n = 4'h0;
        @(negedge clk);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        checks++;
        if (obs() !== OBS_IDLE) begin
            failures++;
            $display("FAIL b2b_ignored_claim: got %b expected %b", obs(), OBS_IDLE);
        end
        read_dword(4, got);
        checks++;
        if (got !== model[4]) begin
            failures++;
            $display("FAIL b2b_ram: got %h expected %h", got, model[4]);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] d1, d2, got;
        d1 = $urandom; d2 = ~d1;
        @(posedge clk); #1;
        bus.frame_n = 1'b0; bus.irdy_n = 1'b1; bus.ad_i = BASE + 32'h20; bus.c_be_n = CMD_MEM_WR;
        @(posedge clk); #1;
        bus.irdy_n = 1'b0; bus.ad_i = d1; bus.c_be_n = 4'h0;
        @(posedge clk); #1;
        model[8] = d1;
        bus.ad_i = d2;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== OBS_IDLE) begin
            failures++;
            $display("FAIL rst_mid_release: got %b expected %b", obs(), OBS_IDLE);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_bus();
        read_dword(8, got);
        checks++;
        if (got !== model[8]) begin
            failures++;
            $display("FAIL rst_mid_phase1: got %h expected %h", got, model[8]);
        end
        read_dword(9, got);
        checks++;
        if (got !== model[9]) begin
            failures++;
            $display("FAIL rst_mid_phase2: got %h expected %h", got, model[9]);
        end
    endtask

    task automatic test_random();
        dw_arr_t wd, rd; be_arr_t be; wm_arr_t wm;
        int ft, fd, v, start, n, room; logic [4:0] ot, oi; bit to, is_wr;
        for (int it = 0; it < 24; it++) begin
            start = int'($urandom_range(0, 15));
            room  = 16 - start;
            n     = int'($urandom_range(1, (room > 6) ? 6 : room));
            is_wr = 1'($urandom_range(0, 1));
            for (int k = 0; k < 16; k++) begin
                wd[k] = $urandom;
                be[k] = 4'($urandom_range(0, 15));
                wm[k] = ($urandom_range(0, 3) == 0);
            end
            do_burst(is_wr, BASE + 32'(start*4), n, wd, be, wm, rd, ft, fd, v, ot, oi, to);
            checks++;
            if (to || ft !== (is_wr ? 1 : 2) || v !== 0 || ot !== OBS_TURN || oi !== OBS_IDLE) begin
                failures++;
                $display("FAIL rand_%0d_proto: wr=%0d timeout=%0d trdy_cyc=%0d viol=%0d turn=%b idle=%b",
                         it, is_wr, to, ft, v, ot, oi);
            end
            for (int k = 0; k < n; k++) begin
                if (is_wr) begin
                    model[start+k] = merge(model[start+k], wd[k], be[k]);
                end else begin
                    checks++;
                    if (rd[k] !== model[start+k]) begin
                        failures++;
                        $display("FAIL rand_%0d_data[%0d]: got %h expected %h", it, start+k, rd[k], model[start+k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_single_wr_rd();
        test_byte_enables();
        test_burst_wait();
        test_miss();
        test_window_end();
        test_turn_ignore();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
